// File: rtl/bus_pkg.sv
// Shared definitions for the 8-bit bus/valid/ack protocol: ids, header layout, rx FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bus_pkg;

  // Endpoint ids carried in the header dest/src fields
  localparam logic [1:0] ID_B    = 2'b00;
  localparam logic [1:0] ID_SHA  = 2'b01;
  localparam logic [1:0] ID_RSP  = 2'b10;
  localparam logic [1:0] ID_CTRL = 2'b11;

  // Header byte layout: [7:6] dest, [5:4] src, [3:0] payload length minus one
  localparam int HDR_DEST_MSB = 7;
  localparam int HDR_DEST_LSB = 6;
  localparam int HDR_SRC_MSB  = 5;
  localparam int HDR_SRC_LSB  = 4;
  localparam int HDR_LEN_MSB  = 3;
  localparam int HDR_LEN_LSB  = 0;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PAYLOAD = 3'd1,
    CHECK   = 3'd2,
    ACK     = 3'd3,
    DROP    = 3'd4
  } rx_state_t;

  // One stored payload byte with its frame context (11 bits)
  typedef struct packed {
    logic [1:0] src;
    logic       last;
    logic [7:0] data;
  } fifo_entry_t;

  // Payload length 1..16 decoded from a header byte
  function automatic logic [4:0] hdr_len(input logic [7:0] hdr);
    return {1'b0, hdr[HDR_LEN_MSB:HDR_LEN_LSB]} + 5'd1;
  endfunction

endpackage

// File: rtl/frame_fifo.sv
// Payload FIFO with speculative write pointer: frames are written at wr_spec and only become
// visible to the reader once committed; rollback discards the uncommitted tail.
// Latency: committed entry readable the cycle after the commit edge; read data is combinational.
// Backpressure: writer must check free before starting a frame; reader pops via pop when rd_vld.
// Ports:
//   clk, rst          clock, synchronous active-high reset (empties the FIFO)
//   wr_en, wr_dat     speculative write of one entry at wr_spec
//   commit            wr_commit takes the post-write wr_spec value on this edge
//   rollback          wr_spec returns to wr_commit (has priority over wr_en)
//   pop               consume the entry at rd (ignored when rd_vld is low)
//   rd_dat, rd_vld    head entry and its valid (rd != wr_commit)
//   free              DEPTH - (wr_spec - rd)
module frame_fifo
  import bus_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  fifo_entry_t              wr_dat,
  input  logic                     commit,
  input  logic                     rollback,
  input  logic                     pop,
  output fifo_entry_t              rd_dat,
  output logic                     rd_vld,
  output logic [$clog2(DEPTH):0]   free
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  fifo_entry_t   mem [DEPTH];
  logic [PW-1:0] rd;
  logic [PW-1:0] wr_spec;
  logic [PW-1:0] wr_commit;
  logic [PW-1:0] wr_spec_nxt;

  // Commit must include a byte written on the same edge, so it samples the next wr_spec
  always_comb begin
    wr_spec_nxt = wr_spec;
    if (rollback) begin
      wr_spec_nxt = wr_commit;
    end else if (wr_en) begin
      wr_spec_nxt = wr_spec + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd        <= '0;
      wr_spec   <= '0;
      wr_commit <= '0;
    end else begin
      wr_spec <= wr_spec_nxt;
      if (commit) begin
        wr_commit <= wr_spec_nxt;
      end
      if (pop && rd_vld) begin
        rd <= rd + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rollback) begin
      mem[wr_spec[AW-1:0]] <= wr_dat;
    end
  end

  // Extra pointer MSB distinguishes full from empty; differences wrap naturally
  assign rd_vld = (rd != wr_commit);
  assign rd_dat = mem[rd[AW-1:0]];
  assign free   = PW'(DEPTH) - (wr_spec - rd);

endmodule

// File: rtl/bus_rx_responder.sv
// Bus target: stores frames addressed to MY_ID with commit/rollback and acks complete frames.
// Latency: ack and first out_valid one clk after the last frame byte.
// Backpressure: consumer stalls with out_ready=0; frames that do not fit are dropped unacked.
// Optional feature macro: BUS_RX_CHECKSUM_EN (trailing XOR checksum byte per frame).
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   bus_data, bus_valid       shared bus byte and its valid
//   ack                       one-cycle pulse when a frame is accepted
//   out_data/src/last/valid   committed payload byte, its frame source, end-of-frame flag
//   out_ready                 consumer accepts the byte on out_valid & out_ready
//   busy                      receiver FSM not in IDLE
module bus_rx_responder
  import bus_pkg::*;
#(
  parameter logic [1:0] MY_ID       = ID_RSP,
  parameter int         DEPTH       = 16,
  parameter int         TIMEOUT_CYC = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] bus_data,
  input  logic       bus_valid,
  output logic       ack,
  output logic [7:0] out_data,
  output logic [1:0] out_src,
  output logic       out_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy
);

  localparam int PW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  rx_state_t   state, state_nxt;
  logic [3:0]  len_m1, len_m1_nxt;
  logic [1:0]  src, src_nxt;
  logic [4:0]  byte_cnt, byte_cnt_nxt;
  logic [TW-1:0] idle_cnt, idle_cnt_nxt;
`ifdef BUS_RX_CHECKSUM_EN
  logic [7:0]  chk, chk_nxt;
`endif

  logic        fifo_wr_en;
  fifo_entry_t fifo_wr_dat;
  logic        fifo_commit;
  logic        fifo_rollback;
  fifo_entry_t fifo_rd_dat;
  logic        fifo_rd_vld;
  logic [PW-1:0] fifo_free;

  logic        mid_frame;
  logic        timeout;
  logic        hdr_accept;
  logic [4:0]  drop_last;

  frame_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (fifo_wr_en),
    .wr_dat   (fifo_wr_dat),
    .commit   (fifo_commit),
    .rollback (fifo_rollback),
    .pop      (out_valid && out_ready),
    .rd_dat   (fifo_rd_dat),
    .rd_vld   (fifo_rd_vld),
    .free     (fifo_free)
  );

  assign mid_frame  = (state == PAYLOAD) || (state == CHECK) || (state == DROP);
  assign timeout    = mid_frame && !bus_valid && (idle_cnt == TW'(TIMEOUT_CYC - 1));
  assign hdr_accept = (bus_data[HDR_DEST_MSB:HDR_DEST_LSB] == MY_ID)
                      && (fifo_free >= PW'(hdr_len(bus_data)));

  // A dropped frame still occupies the bus for its full length, checksum byte included
`ifdef BUS_RX_CHECKSUM_EN
  assign drop_last = {1'b0, len_m1} + 5'd1;
`else
  assign drop_last = {1'b0, len_m1};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      len_m1   <= '0;
      src      <= '0;
      byte_cnt <= '0;
      idle_cnt <= '0;
`ifdef BUS_RX_CHECKSUM_EN
      chk      <= '0;
`endif
    end else begin
      state    <= state_nxt;
      len_m1   <= len_m1_nxt;
      src      <= src_nxt;
      byte_cnt <= byte_cnt_nxt;
      idle_cnt <= idle_cnt_nxt;
`ifdef BUS_RX_CHECKSUM_EN
      chk      <= chk_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt     = state;
    len_m1_nxt    = len_m1;
    src_nxt       = src;
    byte_cnt_nxt  = byte_cnt;
    idle_cnt_nxt  = idle_cnt;
`ifdef BUS_RX_CHECKSUM_EN
    chk_nxt       = chk;
`endif
    fifo_wr_en    = 1'b0;
    fifo_wr_dat   = '0;
    fifo_commit   = 1'b0;
    fifo_rollback = 1'b0;
    ack           = 1'b0;

    // Idle-gap counter only runs mid-frame and restarts on every valid byte
    if (mid_frame) begin
      if (bus_valid) begin
        idle_cnt_nxt = '0;
      end else if (!timeout) begin
        idle_cnt_nxt = idle_cnt + TW'(1);
      end
    end

    case (state)
      IDLE: begin
        if (bus_valid) begin
          len_m1_nxt   = bus_data[HDR_LEN_MSB:HDR_LEN_LSB];
          src_nxt      = bus_data[HDR_SRC_MSB:HDR_SRC_LSB];
          byte_cnt_nxt = '0;
          idle_cnt_nxt = '0;
`ifdef BUS_RX_CHECKSUM_EN
          chk_nxt      = bus_data;
`endif
          state_nxt    = hdr_accept ? PAYLOAD : DROP;
        end
      end

      PAYLOAD: begin
        if (timeout) begin
          fifo_rollback = 1'b1;
          state_nxt     = IDLE;
        end else if (bus_valid) begin
          fifo_wr_en       = 1'b1;
          fifo_wr_dat.src  = src;
          fifo_wr_dat.last = (byte_cnt == {1'b0, len_m1});
          fifo_wr_dat.data = bus_data;
          byte_cnt_nxt     = byte_cnt + 5'd1;
`ifdef BUS_RX_CHECKSUM_EN
          chk_nxt          = chk ^ bus_data;
          if (byte_cnt == {1'b0, len_m1}) begin
            state_nxt = CHECK;
          end
`else
          if (byte_cnt == {1'b0, len_m1}) begin
            fifo_commit = 1'b1;
            state_nxt   = ACK;
          end
`endif
        end
      end

`ifdef BUS_RX_CHECKSUM_EN
      CHECK: begin
        if (timeout) begin
          fifo_rollback = 1'b1;
          state_nxt     = IDLE;
        end else if (bus_valid) begin
          if (bus_data == chk) begin
            fifo_commit = 1'b1;
            state_nxt   = ACK;
          end else begin
            fifo_rollback = 1'b1;
            state_nxt     = IDLE;
          end
        end
      end
`endif

      // Bus byte arriving during the ack cycle is not part of any frame
      ACK: begin
        ack       = 1'b1;
        state_nxt = IDLE;
      end

      DROP: begin
        if (timeout) begin
          fifo_rollback = 1'b1;
          state_nxt     = IDLE;
        end else if (bus_valid) begin
          if (byte_cnt == drop_last) begin
            state_nxt = IDLE;
          end else begin
            byte_cnt_nxt = byte_cnt + 5'd1;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Outputs read as zero whenever nothing committed is waiting
  assign out_valid = fifo_rd_vld;
  assign out_data  = fifo_rd_vld ? fifo_rd_dat.data : 8'h00;
  assign out_src   = fifo_rd_vld ? fifo_rd_dat.src  : 2'b00;
  assign out_last  = fifo_rd_vld ? fifo_rd_dat.last : 1'b0;
  assign busy      = (state != IDLE);

endmodule
